// File: rtl/ram_avalon_arb_if.sv
// rtl/ram_avalon_arb_if.sv - Avalon-MM signal bundle for the two-master RAM arbiter
interface ram_avalon_arb_if #(
  parameter int a_width = 7
);
  logic [a_width-1:0] m0_address, m1_address;
  logic               m0_read, m1_read;
  logic               m0_write, m1_write;
  logic [3:0]         m0_byteenable, m1_byteenable;
  logic [31:0]        m0_writedata, m1_writedata;
  logic               m0_waitrequest, m1_waitrequest;
  logic [31:0]        m0_readdata, m1_readdata;
  logic               m0_readdatavalid, m1_readdatavalid;

  logic [a_width-1:0] s_address;
  logic               s_chipselect;
  logic               s_write;
  logic [3:0]         s_byteenable;
  logic [31:0]        s_writedata;
  logic [31:0]        s_readdata;

  // Arbiter side: accepts master commands, drives the RAM port.
  modport slave (
    input  m0_address, m1_address, m0_read, m1_read, m0_write, m1_write,
    input  m0_byteenable, m1_byteenable, m0_writedata, m1_writedata,
    output m0_waitrequest, m1_waitrequest, m0_readdata, m1_readdata,
    output m0_readdatavalid, m1_readdatavalid,
    output s_address, s_chipselect, s_write, s_byteenable, s_writedata,
    input  s_readdata
  );

  // Environment side: masters plus the RAM itself.
  modport master (
    output m0_address, m1_address, m0_read, m1_read, m0_write, m1_write,
    output m0_byteenable, m1_byteenable, m0_writedata, m1_writedata,
    input  m0_waitrequest, m1_waitrequest, m0_readdata, m1_readdata,
    input  m0_readdatavalid, m1_readdatavalid,
    input  s_address, s_chipselect, s_write, s_byteenable, s_writedata,
    output s_readdata
  );
endinterface

// File: rtl/ram_avalon_arb.sv
// rtl/ram_avalon_arb.sv - two-master arbiter in front of a single-port Avalon RAM
module ram_avalon_arb #(
  parameter int a_width    = 7,
  parameter bit rr_en      = 1'b1,
  parameter int starve_lim = 8
) (
  input logic             clk,
  input logic             resetn,
  ram_avalon_arb_if.slave bus
);
  logic               req0, req1;
  logic               gnt_vld, gnt_id, gnt_wr;
  logic               lg, rv, rown;
  logic [7:0]         sc;
  logic               starved;
  logic [a_width-1:0] sel_addr;
  logic [3:0]         sel_be;
  logic [31:0]        sel_wd;

  assign req0    = bus.m0_read | bus.m0_write;
  assign req1    = bus.m1_read | bus.m1_write;
  assign starved = (sc == 8'(starve_lim));

  // Grant is purely combinational so a lone requester is accepted with zero wait.
  always_comb begin
    gnt_vld = req0 | req1;
    gnt_id  = 1'b0;
    if (req0 && req1) begin
      if (rr_en) gnt_id = ~lg;
      else       gnt_id = starved;
    end else if (req1) begin
      gnt_id = 1'b1;
    end
  end

  always_comb begin
    gnt_wr   = gnt_id ? bus.m1_write      : bus.m0_write;
    sel_addr = gnt_id ? bus.m1_address    : bus.m0_address;
    sel_be   = gnt_id ? bus.m1_byteenable : bus.m0_byteenable;
    sel_wd   = gnt_id ? bus.m1_writedata  : bus.m0_writedata;
  end

  assign bus.m0_waitrequest = req0 & gnt_id;
  assign bus.m1_waitrequest = req1 & ~gnt_id;

  assign bus.s_chipselect = gnt_vld;
  assign bus.s_write      = gnt_vld & gnt_wr;
  assign bus.s_address    = gnt_vld ? sel_addr : {a_width{1'b0}};
  assign bus.s_byteenable = gnt_vld ? sel_be   : 4'h0;
  assign bus.s_writedata  = gnt_vld ? sel_wd   : 32'h0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lg   <= 1'b1;
      sc   <= 8'h00;
      rv   <= 1'b0;
      rown <= 1'b0;
    end else begin
      if (gnt_vld) lg <= gnt_id;
      rv <= gnt_vld & ~gnt_wr;
      if (gnt_vld && !gnt_wr) rown <= gnt_id;
      // Count consecutive stalled cycles of master 1; saturate rather than wrap.
      if (req1 && !gnt_id) begin
        if (sc != 8'hff) sc <= sc + 8'd1;
      end else begin
        sc <= 8'h00;
      end
    end
  end

  assign bus.m0_readdatavalid = rv & ~rown;
  assign bus.m1_readdatavalid = rv & rown;
  assign bus.m0_readdata      = bus.s_readdata;
  assign bus.m1_readdata      = bus.s_readdata;
endmodule

// File: tb/tb_ram_avalon_arb.sv
// tb/tb_ram_avalon_arb.sv - randomized self-checking bench for ram_avalon_arb (round-robin and fixed-priority)
module tb_ram_avalon_arb;
  localparam int AW = 7;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  ram_avalon_arb_if #(.a_width(AW)) bus_rr ();
  ram_avalon_arb_if #(.a_width(AW)) bus_fp ();

  ram_avalon_arb #(.a_width(AW), .rr_en(1'b1), .starve_lim(8)) dut_rr (
    .clk(clk), .resetn(resetn), .bus(bus_rr));
  ram_avalon_arb #(.a_width(AW), .rr_en(1'b0), .starve_lim(3)) dut_fp (
    .clk(clk), .resetn(resetn), .bus(bus_fp));

  // Shared master stimulus, indexed by master id.
  logic          s_rd [2];
  logic          s_wr [2];
  logic [AW-1:0] s_ad [2];
  logic [3:0]    s_be [2];
  logic [31:0]   s_wd [2];

  assign bus_rr.m0_read = s_rd[0];       assign bus_fp.m0_read = s_rd[0];
  assign bus_rr.m1_read = s_rd[1];       assign bus_fp.m1_read = s_rd[1];
  assign bus_rr.m0_write = s_wr[0];      assign bus_fp.m0_write = s_wr[0];
  assign bus_rr.m1_write = s_wr[1];      assign bus_fp.m1_write = s_wr[1];
  assign bus_rr.m0_address = s_ad[0];    assign bus_fp.m0_address = s_ad[0];
  assign bus_rr.m1_address = s_ad[1];    assign bus_fp.m1_address = s_ad[1];
  assign bus_rr.m0_byteenable = s_be[0]; assign bus_fp.m0_byteenable = s_be[0];
  assign bus_rr.m1_byteenable = s_be[1]; assign bus_fp.m1_byteenable = s_be[1];
  assign bus_rr.m0_writedata = s_wd[0];  assign bus_fp.m0_writedata = s_wd[0];
  assign bus_rr.m1_writedata = s_wd[1];  assign bus_fp.m1_writedata = s_wd[1];

  // Behavioural RAMs behind each arbiter, zeroed at start.
  logic [31:0] ram_rr [128] = '{default: 32'h0};
  logic [31:0] ram_fp [128] = '{default: 32'h0};

  always @(posedge clk) begin
    if (bus_rr.s_chipselect) begin
      if (bus_rr.s_write) begin
        for (int b = 0; b < 4; b++)
          if (bus_rr.s_byteenable[b]) ram_rr[bus_rr.s_address][8*b +: 8] <= bus_rr.s_writedata[8*b +: 8];
      end else begin
        bus_rr.s_readdata <= ram_rr[bus_rr.s_address];
      end
    end
  end

  always @(posedge clk) begin
    if (bus_fp.s_chipselect) begin
      if (bus_fp.s_write) begin
        for (int b = 0; b < 4; b++)
          if (bus_fp.s_byteenable[b]) ram_fp[bus_fp.s_address][8*b +: 8] <= bus_fp.s_writedata[8*b +: 8];
      end else begin
        bus_fp.s_readdata <= ram_fp[bus_fp.s_address];
      end
    end
  end

  // Reference model state per DUT (0 = round-robin, 1 = fixed priority).
  int          n_cmp = 0;
  int          n_err = 0;
  bit          mode_rr [2] = '{1'b1, 1'b0};
  int          lim     [2] = '{8, 3};
  int          last_g  [2];
  int          stall_n [2];
  bit          pend_v  [2];
  int          pend_own[2];
  logic [31:0] pend_d  [2];
  logic [31:0] ref_mem [2][128];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [5:0] obs_flags(input int k);
    if (k == 0)
      return {bus_rr.m1_waitrequest, bus_rr.m0_waitrequest, bus_rr.s_chipselect,
              bus_rr.s_write, bus_rr.m1_readdatavalid, bus_rr.m0_readdatavalid};
    return {bus_fp.m1_waitrequest, bus_fp.m0_waitrequest, bus_fp.s_chipselect,
            bus_fp.s_write, bus_fp.m1_readdatavalid, bus_fp.m0_readdatavalid};
  endfunction

  function automatic logic [42:0] obs_slave(input int k);
    if (k == 0) return {bus_rr.s_address, bus_rr.s_byteenable, bus_rr.s_writedata};
    return {bus_fp.s_address, bus_fp.s_byteenable, bus_fp.s_writedata};
  endfunction

  function automatic logic [63:0] obs_rdata(input int k);
    if (k == 0) return {bus_rr.m1_readdata, bus_rr.m0_readdata};
    return {bus_fp.m1_readdata, bus_fp.m0_readdata};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      last_g[k]  = 1;
      stall_n[k] = 0;
      pend_v[k]  = 1'b0;
    end
  endtask

  task automatic idle();
    for (int m = 0; m < 2; m++) begin
      s_rd[m] = 1'b0; s_wr[m] = 1'b0; s_ad[m] = '0; s_be[m] = 4'h0; s_wd[m] = 32'h0;
    end
  endtask

  // Called just after a falling edge with inputs applied; checks, then advances one clock.
  task automatic cycle();
    #1;
    for (int k = 0; k < 2; k++) begin
      bit          req0, req1, gv, gi, wr;
      logic [5:0]  ef;
      logic [42:0] es;
      req0 = s_rd[0] | s_wr[0];
      req1 = s_rd[1] | s_wr[1];
      gv = req0 | req1;
      gi = 1'b0;
      if (req0 && req1) begin
        if (mode_rr[k]) gi = (last_g[k] == 0);
        else            gi = (stall_n[k] >= lim[k]);
      end else if (req1) begin
        gi = 1'b1;
      end
      wr = gv && s_wr[gi];
      ef = {req1 && !(gv && gi), req0 && !(gv && !gi), gv, wr,
            pend_v[k] && pend_own[k] == 1, pend_v[k] && pend_own[k] == 0};
      es = gv ? {s_ad[gi], s_be[gi], s_wd[gi]} : 43'h0;
      check($sformatf("flags%0d", k), 64'(obs_flags(k)), 64'(ef));
      check($sformatf("slave%0d", k), 64'(obs_slave(k)), 64'(es));
      if (pend_v[k]) check($sformatf("rdata%0d", k), obs_rdata(k), {pend_d[k], pend_d[k]});
      if (resetn) begin
        pend_v[k] = gv && !wr;
        if (pend_v[k]) begin
          pend_own[k] = gi ? 1 : 0;
          pend_d[k]   = ref_mem[k][s_ad[gi]];
        end
        if (wr)
          for (int b = 0; b < 4; b++)
            if (s_be[gi][b]) ref_mem[k][s_ad[gi]][8*b +: 8] = s_wd[gi][8*b +: 8];
        if (gv) last_g[k] = gi ? 1 : 0;
        stall_n[k] = (req1 && gv && !gi) ? stall_n[k] + 1 : 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    resetn = 1'b0;
    idle();
    model_reset();
    repeat (n) cycle();
    resetn = 1'b1;
  endtask

  task automatic set_cmd(input int m, input bit rd, input bit wr, input logic [AW-1:0] ad,
                         input logic [3:0] be, input logic [31:0] wd);
    s_rd[m] = rd; s_wr[m] = wr; s_ad[m] = ad; s_be[m] = be; s_wd[m] = wd;
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    model_reset();
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 128; a++) ref_mem[k][a] = 32'h0;
    @(negedge clk);
    do_reset(2);

    // Lone m0 read at 0x05, then its return.
    set_cmd(0, 1'b1, 1'b0, 7'h05, 4'hf, 32'h0);
    #1;
    check("r036_wait", 64'(bus_rr.m0_waitrequest), 64'(0));
    check("r036_addr", 64'({bus_rr.s_chipselect, bus_rr.s_write, bus_rr.s_address}), 64'({1'b1, 1'b0, 7'h05}));
    cycle();
    idle();
    #1;
    check("r036_rdv", 64'({bus_rr.m1_readdatavalid, bus_rr.m0_readdatavalid}), 64'(2'b01));
    cycle();

    // Both reading continuously from reset.
    do_reset(1);
    set_cmd(0, 1'b1, 1'b0, 7'h01, 4'hf, 32'h0);
    set_cmd(1, 1'b1, 1'b0, 7'h02, 4'hf, 32'h0);
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("r037_rr%0d", i), 64'(bus_rr.m0_waitrequest), 64'(i % 2));
      check($sformatf("r039_fp%0d", i), 64'(bus_fp.m1_waitrequest), 64'(i % 4 != 3));
      cycle();
    end

    // Partial write by m1, read back by m0.
    idle();
    set_cmd(1, 1'b0, 1'b1, 7'h10, 4'b0011, 32'hDEADBEEF);
    cycle();
    idle();
    set_cmd(0, 1'b1, 1'b0, 7'h10, 4'hf, 32'h0);
    cycle();
    idle();
    #1;
    check("r038_data", 64'(bus_rr.m0_readdata), 64'(32'h0000BEEF));
    check("r038_rdv", 64'({bus_rr.m1_readdatavalid, bus_rr.m0_readdatavalid}), 64'(2'b01));
    cycle();

    // Read and write together are a write.
    set_cmd(0, 1'b1, 1'b1, 7'h20, 4'hf, 32'h1);
    #1;
    check("r040_write", 64'(bus_rr.s_write), 64'(1));
    cycle();
    idle();
    cycle();

    // Reset with an m1 read in flight.
    set_cmd(1, 1'b1, 1'b0, 7'h03, 4'hf, 32'h0);
    cycle();
    do_reset(1);
    check("r041_rdv", 64'(bus_rr.m1_readdatavalid), 64'(0));
    set_cmd(0, 1'b1, 1'b0, 7'h04, 4'hf, 32'h0);
    set_cmd(1, 1'b1, 1'b0, 7'h05, 4'hf, 32'h0);
    #1;
    check("r041_win", 64'({bus_rr.m1_waitrequest, bus_rr.m0_waitrequest}), 64'(2'b10));
    cycle();

    // Randomized traffic, with occasional resets.
    for (int i = 0; i < 600; i++) begin
      for (int m = 0; m < 2; m++) begin
        int kind;
        kind = (($urandom_range(0, 3)) == 0) ? 3 : int'($urandom_range(0, 2));
        set_cmd(m, kind == 0 || kind == 2, kind == 1 || kind == 2,
                AW'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 32'($urandom));
      end
      if ($urandom_range(0, 79) == 0) do_reset(1);
      else cycle();
    end
    idle();
    cycle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
